mux_arbiter4: RTL and testbench
===============================

# mux_arbiter4

Four-requester round-robin arbiter that shares one four-way cascaded select mux (first/second/third/fourth data inputs) between independent CPU-side requesters. It registers a one-hot grant, holds it for the duration of a requester's transaction, enforces a maximum hold time, and drives the mux's three cascaded control lines so that exactly the granted requester's data reaches the shared output. It sits between the requesting units and the shared mux/bus datapath.

## Interface
- MAX_HOLD, 16, max consecutive cycles one requester may hold the grant while another waits; 0 disables timeout
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  4  request per requester; bit i maps to mux input i (0=first … 3=fourth)
- grant  output  4  registered one-hot grant, or all-zero
- control1  output  1  mux select for first = grant[0]
- control2  output  1  mux select for second = grant[1]
- control3  output  1  mux select for third = grant[2]
- busy  output  1  any grant bit set
- timed_out  output  1  one-cycle pulse on a forced handoff

## Operation
- Reset values: grant=4'b0000, control1..3=0, busy=0, timed_out=0, state=IDLE, rr pointer=0 (requester 0 highest priority), hold count=0.
- States: IDLE (no grant), GRANTED (one grant bit set).
- Arbitration: rotating priority starting at pointer p; pick = first i in order p, p+1, …, p+3 (mod 4) with req[i]=1. After granting i, pointer ← (i+1) mod 4.
- IDLE: if req≠0 → GRANTED with grant=onehot(pick), hold count=0; else stay.
- GRANTED, owner g:
  - req[g]=1, no timeout → keep grant, hold count+1 (saturating).
  - req[g]=0 (release) → arbitrate among remaining req same cycle; new grant next cycle (zero-bubble handoff), or IDLE if none.
  - Timeout: MAX_HOLD≠0, hold count = MAX_HOLD−1, and any other req bit set → forced handoff to pick excluding g; timed_out=1 for that one cycle. If no other requester, keep g and reset hold count to 0 (no pulse).
- control outputs are pure combinational decodes of registered grant; grant[3] alone or no grant leaves all controls 0, selecting fourth by the mux's cascade — busy distinguishes the two.
- Hold count width: $clog2(MAX_HOLD+1), minimum 1.
- Simultaneous release and timeout: treat as release (timed_out=0).
- Reset mid-transaction: grant drops to 0 the cycle after reset is sampled, pointer returns to 0.

## Timing
- Request-to-grant latency: 1 cycle (req sampled edge N, grant valid after edge N+1).
- Release-to-handoff: req[g] low at edge M → new grant valid after edge M+1; never two grant bits set, never a gap cycle when another req is pending.
- Timeout: with continuous req[g] and competing requester, grant held exactly MAX_HOLD cycles.
- timed_out coincides with the first cycle of the new grant.
- No combinational path req→grant; controls depend only on flops.

## Structure
- Package mux_arb_pkg: NUM_REQ=4 localparam, state enum {IDLE, GRANTED}, onehot/index conversion functions.
- Sub-module rr_pick4: combinational rotating-priority picker (inputs req[3:0], ptr[1:0], exclude mask; outputs onehot pick, valid). Top holds FSM, pointer, hold counter, outputs.

## Test plan
- Reset then req=4'b0110 → after 1 cycle grant=4'b0010, control2=1, busy=1; pointer advances to 2.
- Owner 1 drops req, req=4'b0100 remaining → grant=4'b0100 next cycle, control3=1, no idle cycle.
- All req=4'b1111 held, each owner releases after 1 cycle → grant order 0,1,2,3,0 with 1-cycle tenure each.
- MAX_HOLD=4, req[0] held, req[3] asserted → grant[0] for exactly 4 cycles, then grant=4'b1000, all controls 0, busy=1, timed_out pulse 1 cycle.
- MAX_HOLD=4, req[0] held alone for 20 cycles → grant stays 4'b0001, timed_out never asserts.
- reset asserted while grant=4'b0100 → next cycle grant=0, busy=0; then req=4'b1100 → grant=4'b0100 (pointer back to 0, requester 2 first eligible).

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the four-requester mux arbiter.
//   NUM_REQ   : number of requesters sharing the cascaded mux
//   state_t   : arbiter FSM states (IDLE = no grant, GRANTED = one owner)
//   to_onehot : 2-bit requester index -> one-hot vector
//   to_index  : one-hot vector -> 2-bit requester index (0 when empty)
package mux_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [1:0] idx);
    to_onehot      = '0;
    to_onehot[idx] = 1'b1;
  endfunction

  function automatic logic [1:0] to_index(input logic [NUM_REQ-1:0] oh);
    to_index = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) to_index = 2'(i);
    end
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker for four requesters.
//   req   in  4 : raw request vector
//   ptr   in  2 : requester with highest priority this cycle
//   excl  in  4 : requesters removed from consideration (current owner)
//   pick  out 4 : one-hot winner, or zero when nobody is eligible
//   valid out 1 : a winner exists
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic [3:0] excl,
  output logic [3:0] pick,
  output logic       valid
);

  logic [3:0] cand;

  assign cand = req & ~excl;

  // Scan ptr, ptr+1, ... (mod 4); the 2-bit add wraps naturally.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [1:0] idx;
      idx = ptr + 2'(k);
      if (!valid && cand[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter4.sv
// Round-robin arbiter sharing one four-way cascaded select mux.
// Holds a registered one-hot grant for the duration of a requester's
// transaction, hands off with no bubble on release, and forces a handoff
// after MAX_HOLD cycles when another requester is waiting.
//   clk       in  1 : rising-edge clock
//   reset     in  1 : synchronous active-high reset
//   req       in  4 : request per requester (bit i -> mux input i)
//   grant     out 4 : registered one-hot grant, or zero
//   control1  out 1 : mux select for first  (grant[0])
//   control2  out 1 : mux select for second (grant[1])
//   control3  out 1 : mux select for third  (grant[2])
//   busy      out 1 : any grant bit set
//   timed_out out 1 : one-cycle pulse with the first cycle of a forced grant
module mux_arbiter4
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       control1,
  output logic       control2,
  output logic       control3,
  output logic       busy,
  output logic       timed_out
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] LAST    = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
  localparam logic [HW-1:0] CNT_MAX = {HW{1'b1}};

  state_t          state, state_d;
  logic [3:0]      grant_d;
  logic [1:0]      ptr, ptr_d;
  logic [HW-1:0]   cnt, cnt_d;
  logic            to_d;

  logic [3:0]      pick;
  logic            pvalid;
  logic [1:0]      owner;
  logic            hold_last;

  // Excluding the owner covers both cases that arbitrate while GRANTED:
  // on release its req is already low, on timeout it must not win again.
  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr),
    .excl  (grant),
    .pick  (pick),
    .valid (pvalid)
  );

  assign owner     = to_index(grant);
  assign hold_last = (MAX_HOLD != 0) && (cnt == LAST);

  always_comb begin
    state_d = state;
    grant_d = grant;
    ptr_d   = ptr;
    cnt_d   = cnt;
    to_d    = 1'b0;
    case (state)
      IDLE: begin
        if (pvalid) begin
          state_d = GRANTED;
          grant_d = pick;
          ptr_d   = to_index(pick) + 2'd1;
          cnt_d   = '0;
        end
      end
      GRANTED: begin
        if (!req[owner]) begin
          // Release wins over a coincident timeout: no pulse.
          cnt_d = '0;
          if (pvalid) begin
            grant_d = pick;
            ptr_d   = to_index(pick) + 2'd1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (hold_last) begin
          cnt_d = '0;
          if (pvalid) begin
            grant_d = pick;
            ptr_d   = to_index(pick) + 2'd1;
            to_d    = 1'b1;
          end
        end else if (cnt != CNT_MAX) begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= '0;
      cnt       <= '0;
      timed_out <= 1'b0;
    end else begin
      state     <= state_d;
      grant     <= grant_d;
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      timed_out <= to_d;
    end
  end

  // Grant on requester 3 (or no grant) leaves all selects low, which the
  // cascade resolves to the fourth input; busy tells the two apart.
  assign control1 = grant[0];
  assign control2 = grant[1];
  assign control3 = grant[2];
  assign busy     = |grant;

endmodule

// File: tb/tb_mux_arbiter4.sv
// Directed testbench for mux_arbiter4 (MAX_HOLD = 4).
module tb_mux_arbiter4;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic       control1, control2, control3, busy, timed_out;

  int checks = 0;
  int errors = 0;

  mux_arbiter4 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .grant     (grant),
    .control1  (control1),
    .control2  (control2),
    .control3  (control3),
    .busy      (busy),
    .timed_out (timed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
    checks++;
    if ({control1, control2, control3} !== 3'b000) begin errors++; $display("FAIL reset_controls got %b want 000", {control1, control2, control3}); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (timed_out !== 1'b0) begin errors++; $display("FAIL reset_timed_out got %b want 0", timed_out); end
  endtask

  task automatic test_grant();
    req = 4'b0110;
    step();
    checks++;
    if (grant !== 4'b0010) begin errors++; $display("FAIL first_grant got %b want 0010", grant); end
    checks++;
    if ({control1, control2, control3} !== 3'b010) begin errors++; $display("FAIL first_controls got %b want 010", {control1, control2, control3}); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL first_busy got %b want 1", busy); end
  endtask

  task automatic test_handoff();
    req = 4'b0100;
    step();
    checks++;
    if (grant !== 4'b0100) begin errors++; $display("FAIL handoff_grant got %b want 0100", grant); end
    checks++;
    if ({control1, control2, control3} !== 3'b001) begin errors++; $display("FAIL handoff_controls got %b want 001", {control1, control2, control3}); end
    checks++;
    if (timed_out !== 1'b0) begin errors++; $display("FAIL handoff_timed_out got %b want 0", timed_out); end
    req = 4'b0000;
    step();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL release_idle got grant=%b busy=%b want 0000/0", grant, busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [5];
    logic [3:0] prev;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    do_reset();
    prev = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      // Everyone requests except the current owner, which releases.
      req = 4'b1111 & ~prev;
      step();
      checks++;
      if (grant !== exp_seq[i]) begin errors++; $display("FAIL rr_order[%0d] got %b want %b", i, grant, exp_seq[i]); end
      prev = exp_seq[i];
    end
    req = 4'b0000;
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle busy got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (grant !== 4'b0001 || timed_out !== 1'b0) begin errors++; $display("FAIL timeout_hold[%0d] got grant=%b to=%b want 0001/0", i, grant, timed_out); end
    end
    step();
    checks++;
    if (grant !== 4'b1000) begin errors++; $display("FAIL timeout_grant got %b want 1000", grant); end
    checks++;
    if ({control1, control2, control3} !== 3'b000 || busy !== 1'b1) begin errors++; $display("FAIL timeout_ctrl got ctl=%b busy=%b want 000/1", {control1, control2, control3}, busy); end
    checks++;
    if (timed_out !== 1'b1) begin errors++; $display("FAIL timeout_pulse got %b want 1", timed_out); end
    step();
    checks++;
    if (timed_out !== 1'b0 || grant !== 4'b1000) begin errors++; $display("FAIL timeout_after got grant=%b to=%b want 1000/0", grant, timed_out); end
    req = 4'b0000;
    step();
  endtask

  task automatic test_hold_alone();
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (grant !== 4'b0001 || timed_out !== 1'b0) begin errors++; $display("FAIL hold_alone[%0d] got grant=%b to=%b want 0001/0", i, grant, timed_out); end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_release_at_timeout();
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (grant !== 4'b0001) begin errors++; $display("FAIL rel_to_hold[%0d] got %b want 0001", i, grant); end
    end
    // Owner releases on the same edge its hold limit would force a handoff.
    req = 4'b0010;
    step();
    checks++;
    if (grant !== 4'b0010 || timed_out !== 1'b0) begin errors++; $display("FAIL rel_to_handoff got grant=%b to=%b want 0010/0", grant, timed_out); end
    req = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100;
    step();
    checks++;
    if (grant !== 4'b0100) begin errors++; $display("FAIL mid_setup got %b want 0100", grant); end
    reset = 1'b1;
    step();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset got grant=%b busy=%b want 0000/0", grant, busy); end
    reset = 1'b0;
    req = 4'b1100;
    step();
    checks++;
    if (grant !== 4'b0100) begin errors++; $display("FAIL mid_after got %b want 0100", grant); end
    req = 4'b0000;
    step();
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    test_reset();
    test_grant();
    test_handoff();
    test_round_robin();
    test_timeout();
    test_hold_alone();
    test_release_at_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
